// File: rtl/esm_issue_selector.sv
// Issue selector for the ESM candidate window: takes a mask of independent slots and
// issues each set slot exactly once, starting every search at a PRNG-supplied index.
//
// state  | meaning
// IDLE   | waiting for a candidate mask; cand_ready high
// SELECT | one-cycle circular search from rnd over the remaining pending slots
// ISSUE  | issue_idx presented to the consumer, held until issue_ready
module esm_issue_selector #(
  parameter int bs = 16,
  localparam int iw = $clog2(bs)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cand_valid,
  input  logic [0:bs-1] cand_mask,
  output logic          cand_ready,
  input  logic [iw-1:0] rnd,
  output logic          issue_valid,
  output logic [iw-1:0] issue_idx,
  input  logic          issue_ready,
  output logic          batch_done,
  output logic [0:bs-1] pending
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [0:bs-1] pending_nxt;
  logic [0:bs-1] pending_cleared;
  logic [iw-1:0] idx_nxt;
  logic          valid_nxt;
  logic          done_nxt;
  logic [iw-1:0] pick_idx;
  logic [iw-1:0] probe;
  logic          found;

  assign cand_ready = (state == IDLE);

  // Circular search s, s+1, ... wrapping modulo bs through the natural iw-bit overflow.
  always_comb begin
    pick_idx = '0;
    probe    = '0;
    found    = 1'b0;
    for (int k = 0; k < bs; k++) begin
      probe = rnd + iw'(k);
      if (!found && pending[probe]) begin
        pick_idx = probe;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    pending_cleared            = pending;
    pending_cleared[issue_idx] = 1'b0;
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    idx_nxt     = issue_idx;
    valid_nxt   = issue_valid;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (cand_valid) begin
          pending_nxt = cand_mask;
          if (cand_mask == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = SELECT;
          end
        end
      end
      SELECT: begin
        idx_nxt   = pick_idx;
        valid_nxt = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        if (issue_ready) begin
          pending_nxt = pending_cleared;
          valid_nxt   = 1'b0;
          if (pending_cleared == '0) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = SELECT;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= '0;
      issue_idx   <= '0;
      issue_valid <= 1'b0;
      batch_done  <= 1'b0;
    end else begin
      pending     <= pending_nxt;
      issue_idx   <= idx_nxt;
      issue_valid <= valid_nxt;
      batch_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_esm_issue_selector.sv
// Directed bench for esm_issue_selector: vector table of single batches plus
// hand-written sequences for wrap, backpressure, ignored input, reset and full mask.
module tb_esm_issue_selector;

  logic        clk;
  logic        rst;
  logic        cand_valid;
  logic [0:15] cand_mask;
  logic        cand_ready;
  logic [3:0]  rnd;
  logic        issue_valid;
  logic [3:0]  issue_idx;
  logic        issue_ready;
  logic        batch_done;
  logic [0:15] pending;

  int checks;
  int failures;

  esm_issue_selector #(.bs(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cand_valid  (cand_valid),
    .cand_mask   (cand_mask),
    .cand_ready  (cand_ready),
    .rnd         (rnd),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .issue_ready (issue_ready),
    .batch_done  (batch_done),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [0:15] mask;
    logic [3:0]  rnd;
    logic [3:0]  first;
    int          k;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference pick: first set slot in circular order starting at s.
  function automatic logic [3:0] model_pick(input logic [0:15] p, input logic [3:0] s);
    logic [3:0] id;
    model_pick = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      id = s + k[3:0];
      if (p[id]) model_pick = id;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:15] mpend;
    logic [0:15] m;
    logic [3:0]  exp_idx;
    logic [15:0] seen;
    int          cnt;
    int          dup;
    int          done_cyc;

    checks = 0;
    failures = 0;
    rst = 1'b0;
    cand_valid = 1'b0;
    cand_mask = '0;
    rnd = '0;
    issue_ready = 1'b0;

    // slot i is cand_mask[i], i.e. bit 0 is the MSB of the literal
    vecs[0] = '{mask: 16'h8000, rnd: 4'd7,  first: 4'd0,  k: 1};
    vecs[1] = '{mask: 16'h0001, rnd: 4'd0,  first: 4'd15, k: 1};
    vecs[2] = '{mask: 16'h0100, rnd: 4'd9,  first: 4'd7,  k: 1};
    vecs[3] = '{mask: 16'hC003, rnd: 4'd3,  first: 4'd14, k: 4};
    vecs[4] = '{mask: 16'h0F00, rnd: 4'd6,  first: 4'd6,  k: 4};
    vecs[5] = '{mask: 16'h2020, rnd: 4'd10, first: 4'd10, k: 2};
    vecs[6] = '{mask: 16'hFFFF, rnd: 4'd15, first: 4'd15, k: 16};

    step();
    step();
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_issue_idx", 32'(issue_idx), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_batch_done", 32'(batch_done), 32'd0);
    chk("rst_cand_ready", 32'(cand_ready), 32'd1);
    rst = 1'b1;
    step();

    // Table: each batch drained with issue_ready high and rnd held constant.
    for (int v = 0; v < 7; v++) begin
      cand_valid = 1'b1;
      cand_mask = vecs[v].mask;
      rnd = vecs[v].rnd;
      issue_ready = 1'b1;
      step();
      cand_valid = 1'b0;
      chk($sformatf("v%0d_accept_ready", v), 32'(cand_ready), 32'd0);
      chk($sformatf("v%0d_accept_pending", v), 32'(pending), 32'(vecs[v].mask));
      mpend = vecs[v].mask;
      for (int j = 0; j < vecs[v].k; j++) begin
        step();
        exp_idx = model_pick(mpend, vecs[v].rnd);
        if (j == 0) chk($sformatf("v%0d_first_idx", v), 32'(issue_idx), 32'(vecs[v].first));
        chk($sformatf("v%0d_valid_%0d", v, j), 32'(issue_valid), 32'd1);
        chk($sformatf("v%0d_idx_%0d", v, j), 32'(issue_idx), 32'(exp_idx));
        mpend[exp_idx] = 1'b0;
        step();
        chk($sformatf("v%0d_pend_%0d", v, j), 32'(pending), 32'(mpend));
        chk($sformatf("v%0d_done_%0d", v, j), 32'(batch_done), (j == vecs[v].k - 1) ? 32'd1 : 32'd0);
      end
      chk($sformatf("v%0d_idle", v), 32'(cand_ready), 32'd1);
      step();
      chk($sformatf("v%0d_done_pulse", v), 32'(batch_done), 32'd0);
    end

    // Empty mask
    issue_ready = 1'b0;
    cand_valid = 1'b1;
    cand_mask = '0;
    step();
    cand_valid = 1'b0;
    chk("empty_done", 32'(batch_done), 32'd1);
    chk("empty_ready", 32'(cand_ready), 32'd1);
    chk("empty_valid", 32'(issue_valid), 32'd0);
    step();
    chk("empty_done_pulse", 32'(batch_done), 32'd0);
    chk("empty_valid2", 32'(issue_valid), 32'd0);

    // Wrap search: slots {2,9}, rnd=12 then rnd=5
    m = '0;
    m[2] = 1'b1;
    m[9] = 1'b1;
    cand_valid = 1'b1;
    cand_mask = m;
    rnd = 4'd12;
    step();
    cand_valid = 1'b0;
    step();
    chk("wrap_first_idx", 32'(issue_idx), 32'd2);
    rnd = 4'd5;
    step();
    chk("wrap_rnd_ignored", 32'(issue_idx), 32'd2);
    chk("wrap_hold_valid", 32'(issue_valid), 32'd1);
    issue_ready = 1'b1;
    step();
    chk("wrap_hs_valid", 32'(issue_valid), 32'd0);
    step();
    chk("wrap_second_idx", 32'(issue_idx), 32'd9);
    step();
    chk("wrap_done", 32'(batch_done), 32'd1);
    issue_ready = 1'b0;
    step();

    // Backpressure on slot 5, new mask offered while busy
    cand_valid = 1'b1;
    cand_mask = 16'h0400;
    rnd = 4'd0;
    step();
    cand_mask = 16'h00F0;
    chk("bp_ready_busy", 32'(cand_ready), 32'd0);
    step();
    chk("bp_valid", 32'(issue_valid), 32'd1);
    chk("bp_idx", 32'(issue_idx), 32'd5);
    for (int i = 0; i < 6; i++) begin
      rnd = 4'(i * 3);
      step();
      chk($sformatf("bp_hold_valid_%0d", i), 32'(issue_valid), 32'd1);
      chk($sformatf("bp_hold_idx_%0d", i), 32'(issue_idx), 32'd5);
      chk($sformatf("bp_hold_pend_%0d", i), 32'(pending), 32'h0400);
      chk($sformatf("bp_hold_ready_%0d", i), 32'(cand_ready), 32'd0);
    end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    chk("bp_done", 32'(batch_done), 32'd1);
    chk("bp_pend_empty", 32'(pending), 32'd0);
    chk("bp_idle", 32'(cand_ready), 32'd1);
    step();
    cand_valid = 1'b0;
    chk("ign_late_accept", 32'(pending), 32'h00F0);
    chk("ign_done_clear", 32'(batch_done), 32'd0);
    step();
    chk("ign_issue_valid", 32'(issue_valid), 32'd1);

    // Reset mid-ISSUE with pending 00F0
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(issue_valid), 32'd0);
    chk("midrst_pending", 32'(pending), 32'd0);
    chk("midrst_idx", 32'(issue_idx), 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("midrst_ready", 32'(cand_ready), 32'd1);
    chk("midrst_no_done", 32'(batch_done), 32'd0);
    step();
    chk("midrst_no_done2", 32'(batch_done), 32'd0);

    // Full mask, random rnd every cycle
    issue_ready = 1'b1;
    cand_valid = 1'b1;
    cand_mask = 16'hFFFF;
    step();
    cand_valid = 1'b0;
    seen = '0;
    cnt = 0;
    dup = 0;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      rnd = 4'($urandom_range(15, 0));
      if (issue_valid) begin
        if (seen[issue_idx]) dup++;
        seen[issue_idx] = 1'b1;
        cnt++;
      end
      if (batch_done && done_cyc < 0) done_cyc = cyc;
    end
    chk("full_count", 32'(cnt), 32'd16);
    chk("full_dups", 32'(dup), 32'd0);
    chk("full_seen", 32'(seen), 32'hFFFF);
    chk("full_done_cycle", 32'(done_cyc), 32'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
